// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Bundles the MEM/WB writeback fields, the two ID-stage read ports and the
// status outputs of the writeback register file into one interface.
//   master : pipeline side; drives the MEM/WB fields and read addresses,
//            observes read data, writeback value, retire count and halt
//   slave  : register file side; the reverse directions
// Signal names keep the pipeline's existing field names.
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic             RegWrite;
  logic [1:0]       MemtoReg;
  logic [31:0]      read_data;
  logic [31:0]      aluout;
  logic [31:0]      PC_plus_4;
  logic [31:0]      Ins;
  logic [4:0]       wr_addr;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] retired_count;
  logic             halt;

  modport master (
    output RegWrite, MemtoReg, read_data, aluout, PC_plus_4, Ins,
           wr_addr, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, retired_count, halt
  );

  modport slave (
    input  RegWrite, MemtoReg, read_data, aluout, PC_plus_4, Ins,
           wr_addr, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, retired_count, halt
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage end of the pipeline: selects the writeback value, commits
// it into a 32x32 register file, serves the two ID read ports with a
// same-cycle write bypass, counts retired (non-bubble) instructions and
// latches a sticky halt when the halt instruction reaches writeback.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears registers, count and halt)
//   bus : wb_regfile_if.slave carrying the MEM/WB fields, read addresses,
//         read data, wb_data, retired_count and halt
module wb_regfile #(
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Declaration initialisers give the same power-up state as a reset.
  state_t           state = RUN;
  logic [CNT_W-1:0] count = '0;
  logic [31:0]      regs [32] = '{default: 32'h0};
  logic [31:0]      wb_value;
  logic [31:0]      rs_value;
  logic [31:0]      rt_value;
  logic             we_eff;

  // Writeback source select; code 11 is illegal and yields zero.
  always_comb begin
    wb_value = 32'h0;
    case (bus.MemtoReg)
      2'b00:   wb_value = bus.aluout;
      2'b01:   wb_value = bus.read_data;
      2'b10:   wb_value = bus.PC_plus_4;
      default: wb_value = 32'h0;
    endcase
  end

  // rst is folded in so that the bypass path never shows a write that the
  // reset is about to discard.
  assign we_eff = bus.RegWrite & (bus.wr_addr != 5'd0) & (bus.MemtoReg != 2'b11)
                  & (state == RUN) & ~rst;

  // Read ports: $0 is hard zero, then the in-flight write wins over the array.
  always_comb begin
    rs_value = regs[bus.rs_addr];
    if (bus.rs_addr == 5'd0)
      rs_value = 32'h0;
    else if (we_eff && (bus.rs_addr == bus.wr_addr))
      rs_value = wb_value;

    rt_value = regs[bus.rt_addr];
    if (bus.rt_addr == 5'd0)
      rt_value = 32'h0;
    else if (we_eff && (bus.rt_addr == bus.wr_addr))
      rt_value = wb_value;
  end

  // Register commit, retire counting and the RUN/HALTED machine share one
  // process so reset dominates all of them on the same edge. The halt
  // instruction itself still writes and is counted on its transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h0;
      count <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      if (we_eff)
        regs[bus.wr_addr] <= wb_value;
      if (bus.Ins != 32'h0)
        count <= count + CNT_W'(1);
      if (bus.Ins == HALT_INSN)
        state <= HALTED;
    end
  end

  assign bus.wb_data       = wb_value;
  assign bus.rs_data       = rs_value;
  assign bus.rt_data       = rt_value;
  assign bus.retired_count = count;
  assign bus.halt          = (state == HALTED);

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Directed bench for wb_regfile. Each step drives the MEM/WB fields and
// read addresses, pushes the values the step must produce onto a scoreboard
// queue, and pops/compares them against the design outputs away from the
// clock edge.
module tb_wb_regfile;

  typedef enum int {OBS_WB, OBS_RS, OBS_RT, OBS_CNT, OBS_HALT} obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb_queue [$];

  wb_regfile_if #(.CNT_W(32)) bus ();

  wb_regfile #(
    .HALT_INSN (32'hFFFF_FFFF),
    .CNT_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic        reg_write,
                                input logic [1:0]  memto_reg,
                                input logic [31:0] rdata,
                                input logic [31:0] alu,
                                input logic [31:0] pc4,
                                input logic [31:0] ins,
                                input logic [4:0]  wr,
                                input logic [4:0]  rs,
                                input logic [4:0]  rt);
    bus.RegWrite  = reg_write;
    bus.MemtoReg  = memto_reg;
    bus.read_data = rdata;
    bus.aluout    = alu;
    bus.PC_plus_4 = pc4;
    bus.Ins       = ins;
    bus.wr_addr   = wr;
    bus.rs_addr   = rs;
    bus.rt_addr   = rt;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, rs, rt);
  endtask

  task automatic expect_val(input string tag, input obs_e sel, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sb_queue.push_back(e);
  endtask

  // Drain the scoreboard, comparing each entry to the selected output.
  task automatic check_output();
    exp_t        e;
    logic [31:0] observed;
    while (sb_queue.size() > 0) begin
      e = sb_queue.pop_front();
      case (e.sel)
        OBS_WB:   observed = bus.wb_data;
        OBS_RS:   observed = bus.rs_data;
        OBS_RT:   observed = bus.rt_data;
        OBS_CNT:  observed = bus.retired_count;
        default:  observed = {31'h0, bus.halt};
      endcase
      checks++;
      assert (observed === e.value)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset, then confirm cleared state.
    rst = 1'b1;
    idle(5'd0, 5'd0);
    tick();
    rst = 1'b0;
    idle(5'd5, 5'd31);
    #1;
    expect_val("reset_rs5", OBS_RS, 32'h0);
    expect_val("reset_rt31", OBS_RT, 32'h0);
    expect_val("reset_count", OBS_CNT, 32'h0);
    expect_val("reset_halt", OBS_HALT, 32'h0);
    check_output();

    // Basic ALU writeback to $5.
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h1234_5678, 32'h0, 32'h0000_0001, 5'd5, 5'd0, 5'd0);
    #1;
    expect_val("wb_alu", OBS_WB, 32'h1234_5678);
    check_output();
    tick();
    idle(5'd5, 5'd0);
    #1;
    expect_val("read_r5", OBS_RS, 32'h1234_5678);
    expect_val("count_after_first", OBS_CNT, 32'd1);
    check_output();

    // Source select: load data to $8, link to $31, illegal code to $9.
    apply_stimulus(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0000_1111, 32'h0, 32'h2, 5'd8, 5'd0, 5'd0);
    #1;
    expect_val("wb_load", OBS_WB, 32'hDEAD_BEEF);
    check_output();
    tick();
    apply_stimulus(1'b1, 2'b10, 32'h0, 32'h0000_1111, 32'h0000_0044, 32'h3, 5'd31, 5'd0, 5'd0);
    #1;
    expect_val("wb_link", OBS_WB, 32'h0000_0044);
    check_output();
    tick();
    apply_stimulus(1'b1, 2'b11, 32'h3333_3333, 32'h0000_2222, 32'h4444_4444, 32'h4, 5'd9, 5'd9, 5'd0);
    #1;
    expect_val("wb_illegal", OBS_WB, 32'h0);
    expect_val("no_bypass_illegal", OBS_RS, 32'h0);
    check_output();
    tick();
    idle(5'd8, 5'd31);
    #1;
    expect_val("read_r8", OBS_RS, 32'hDEAD_BEEF);
    expect_val("read_r31", OBS_RT, 32'h0000_0044);
    expect_val("count_after_select", OBS_CNT, 32'd4);
    check_output();
    idle(5'd9, 5'd5);
    #1;
    expect_val("read_r9_unchanged", OBS_RS, 32'h0);
    expect_val("read_r5_kept", OBS_RT, 32'h1234_5678);
    check_output();

    // Same-cycle bypass on both ports, then a dropped write to $0.
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h5, 5'd7, 5'd7, 5'd7);
    #1;
    expect_val("bypass_rs", OBS_RS, 32'hA5A5_A5A5);
    expect_val("bypass_rt", OBS_RT, 32'hA5A5_A5A5);
    check_output();
    tick();
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h6, 5'd0, 5'd0, 5'd7);
    #1;
    expect_val("r0_no_bypass", OBS_RS, 32'h0);
    expect_val("read_r7", OBS_RT, 32'hA5A5_A5A5);
    check_output();
    tick();
    idle(5'd0, 5'd0);
    #1;
    expect_val("r0_after_write", OBS_RS, 32'h0);
    expect_val("count_after_bypass", OBS_CNT, 32'd6);
    check_output();

    // Three instructions, two bubbles, one more instruction.
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h7, 5'd0, 5'd0, 5'd0);
    tick();
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 5'd0);
    tick();
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h9, 5'd0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    tick();
    tick();
    #1;
    expect_val("count_after_bubbles", OBS_CNT, 32'd9);
    check_output();
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    #1;
    expect_val("count_after_instr", OBS_CNT, 32'd10);
    check_output();

    // Halt instruction that also writes $3; its write and count still commit.
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0000_0033, 32'h0, 32'hFFFF_FFFF, 5'd3, 5'd3, 5'd0);
    #1;
    expect_val("halt_before_edge", OBS_HALT, 32'h0);
    expect_val("halt_insn_bypass", OBS_RS, 32'h0000_0033);
    check_output();
    tick();
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0000_0001, 32'h0, 32'h20, 5'd3, 5'd3, 5'd5);
    #1;
    expect_val("halt_set", OBS_HALT, 32'h1);
    expect_val("count_halt_counted", OBS_CNT, 32'd11);
    expect_val("halted_no_bypass", OBS_RS, 32'h0000_0033);
    expect_val("halted_wb_live", OBS_WB, 32'h0000_0001);
    expect_val("halted_read_r5", OBS_RT, 32'h1234_5678);
    check_output();
    tick();
    idle(5'd3, 5'd0);
    #1;
    expect_val("halted_write_ignored", OBS_RS, 32'h0000_0033);
    expect_val("halted_count_frozen", OBS_CNT, 32'd11);
    expect_val("halt_sticky", OBS_HALT, 32'h1);
    check_output();

    // Reset clears halt, count and registers.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(5'd3, 5'd5);
    #1;
    expect_val("rst_halt_clear", OBS_HALT, 32'h0);
    expect_val("rst_count_clear", OBS_CNT, 32'h0);
    expect_val("rst_r3_clear", OBS_RS, 32'h0);
    expect_val("rst_r5_clear", OBS_RT, 32'h0);
    check_output();

    // Reset colliding with a write and a countable instruction.
    rst = 1'b1;
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0000_0055, 32'h0, 32'h30, 5'd4, 5'd4, 5'd0);
    #1;
    expect_val("rst_no_bypass", OBS_RS, 32'h0);
    expect_val("rst_wb_live", OBS_WB, 32'h0000_0055);
    check_output();
    tick();
    rst = 1'b0;
    idle(5'd4, 5'd0);
    #1;
    expect_val("collision_r4", OBS_RS, 32'h0);
    expect_val("collision_count", OBS_CNT, 32'h0);
    check_output();

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
